// File: rtl/vector_sweep_capture_if.sv
// Record stream bundle for vector_sweep_capture.
// master drives rec_valid/rec_vec/rec_resp; slave drives rec_ready.
interface vector_sweep_capture_if #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 1
);
  logic             rec_valid;
  logic             rec_ready;
  logic [N_IN-1:0]  rec_vec;
  logic [N_OUT-1:0] rec_resp;

  modport master (
    output rec_valid,
    output rec_vec,
    output rec_resp,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_vec,
    input  rec_resp,
    output rec_ready
  );
endinterface

// File: rtl/vector_sweep_capture.sv
// Exhaustive vector sweeper: drives dut_in, captures dut_out after SETTLE
// cycles, streams (vec,resp) on rec, folds responses into a MISR signature.
module vector_sweep_capture #(
  parameter int              N_IN      = 2,
  parameter int              N_OUT     = 1,
  parameter int              SETTLE    = 1,
  parameter int              MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature,
  vector_sweep_capture_if.master rec
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SC_LAST = SW'(SETTLE - 1);
  localparam logic [N_IN:0] LAST = (N_IN+1)'((1 << N_IN) - 1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    HOLD,
    DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [N_IN:0]      cnt_q;
  logic [SW-1:0]      sc_q;
  logic [1:0]         mode_q;
  logic [N_IN-1:0]    vec_q;
  logic [N_OUT-1:0]   resp_q;
  logic [MISR_W-1:0]  misr_nxt;
  logic               settled;
  logic               last;

  function automatic logic [N_IN-1:0] map_vec(
    input logic [N_IN-1:0] c,
    input logic [1:0]      m
  );
    logic [N_IN-1:0] v;
    unique case (m)
      2'b01:   v = c ^ (c >> 1);
      2'b10:   v = ~c;
      default: v = c;
    endcase
    return v;
  endfunction

  assign settled = (sc_q == SC_LAST);
  assign last    = (cnt_q == LAST);

  assign misr_nxt = {signature[MISR_W-2:0], 1'b0}
                  ^ (signature[MISR_W-1] ? MISR_POLY : '0)
                  ^ MISR_W'(resp_q);

  assign busy          = (state_q == APPLY) || (state_q == HOLD);
  assign done          = (state_q == DONE);
  assign rec.rec_valid = (state_q == HOLD);
  assign rec.rec_vec   = vec_q;
  assign rec.rec_resp  = resp_q;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = APPLY;
      APPLY: if (settled) state_d = HOLD;
      HOLD:  if (rec.rec_ready) state_d = last ? DONE : APPLY;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      sc_q      <= '0;
      mode_q    <= '0;
      vec_q     <= '0;
      resp_q    <= '0;
      dut_in    <= '0;
      signature <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          cnt_q     <= '0;
          sc_q      <= '0;
          mode_q    <= mode;
          signature <= '0;
          dut_in    <= map_vec('0, mode);
        end
        APPLY: begin
          if (settled) begin
            vec_q  <= dut_in;
            resp_q <= dut_out;
          end else begin
            sc_q <= sc_q + 1'b1;
          end
        end
        HOLD: if (rec.rec_ready) begin
          signature <= misr_nxt;
          // last vector stays on dut_in through DONE and IDLE
          if (!last) begin
            cnt_q  <= cnt_q + 1'b1;
            sc_q   <= '0;
            dut_in <= map_vec(cnt_q[N_IN-1:0] + 1'b1, mode_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sweep_capture.sv
// Randomised self-checking bench for vector_sweep_capture.
// Two instances: A (N_IN=2,SETTLE=1) and B (N_IN=3,SETTLE=3).
module tb_vector_sweep_capture;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic start_g = 1'b0;
  logic ready_g = 1'b1;
  logic [1:0] mode_g = 2'b00;
  logic sel = 1'b0;

  logic [3:0] tt_a = 4'b1000;
  logic [7:0] tt_b = 8'h00;

  logic [1:0] din_a;
  logic [2:0] din_b;
  logic dout_a, dout_b;
  logic busy_a, busy_b, done_a, done_b;
  logic [15:0] sig_a, sig_b;
  logic start_a, start_b;

  vector_sweep_capture_if #(.N_IN(2), .N_OUT(1)) ra ();
  vector_sweep_capture_if #(.N_IN(3), .N_OUT(1)) rb ();

  assign start_a = !sel && start_g;
  assign start_b = sel && start_g;
  assign ra.rec_ready = sel ? 1'b1 : ready_g;
  assign rb.rec_ready = sel ? ready_g : 1'b1;
  assign dout_a = tt_a[din_a];
  assign dout_b = tt_b[din_b];

  vector_sweep_capture #(.N_IN(2), .N_OUT(1), .SETTLE(1)) dut_a (
    .CK(CK), .reset(rst_a), .start(start_a), .mode(mode_g),
    .dut_in(din_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
    .signature(sig_a), .rec(ra)
  );

  vector_sweep_capture #(.N_IN(3), .N_OUT(1), .SETTLE(3)) dut_b (
    .CK(CK), .reset(rst_b), .start(start_b), .mode(mode_g),
    .dut_in(din_b), .dut_out(dout_b), .busy(busy_b), .done(done_b),
    .signature(sig_b), .rec(rb)
  );

  logic g_busy, g_done, g_valid, g_resp;
  logic [2:0] g_vec, g_din;
  logic [15:0] g_sig;
  always_comb begin
    g_busy  = sel ? busy_b : busy_a;
    g_done  = sel ? done_b : done_a;
    g_valid = sel ? rb.rec_valid : ra.rec_valid;
    g_resp  = sel ? rb.rec_resp[0] : ra.rec_resp[0];
    g_vec   = sel ? rb.rec_vec : {1'b0, ra.rec_vec};
    g_din   = sel ? din_b : {1'b0, din_a};
    g_sig   = sel ? sig_b : sig_a;
  end

  int checks = 0;
  int passes = 0;

  int q_vec[$];
  int q_resp[$];
  int busy_cnt, done_cnt, first_valid, post_busy, stall_bad;
  bit timeout;

  function automatic int exp_vec(int n, int m, int i);
    if (m == 1) return i ^ (i >> 1);
    if (m == 2) return (1 << n) - 1 - i;
    return i;
  endfunction

  function automatic int exp_resp(bit s, int v);
    return s ? int'(tt_b[v]) : int'(tt_a[v]);
  endfunction

  function automatic logic [15:0] exp_sig(bit s, int n, int m);
    int acc;
    acc = 0;
    for (int i = 0; i < (1 << n); i++) begin
      acc = acc * 2;
      if (acc >= 65536) acc = (acc - 65536) ^ 'h1021;
      acc = acc ^ exp_resp(s, exp_vec(n, m, i));
    end
    return 16'(acc);
  endfunction

  function automatic int rec_errs(bit s, int n, int m);
    int e;
    e = 0;
    if (q_vec.size() != (1 << n)) return 1000 + q_vec.size();
    for (int i = 0; i < (1 << n); i++) begin
      if (q_vec[i] != exp_vec(n, m, i)) e++;
      if (q_resp[i] != exp_resp(s, exp_vec(n, m, i))) e++;
    end
    return e;
  endfunction

  // Stimulus driver / monitor: runs one sweep on the selected instance.
  task automatic run_sweep(input logic [1:0] m, input bit hold,
                           input int pulse_at, input int stall_idx,
                           input int stall_n);
    int cyc, left, after;
    logic [2:0] sv, sd;
    logic sr;
    cyc = 0; left = stall_n; after = -1;
    sv = '0; sd = '0; sr = 1'b0;
    q_vec.delete(); q_resp.delete();
    busy_cnt = 0; done_cnt = 0; first_valid = -1;
    post_busy = 0; stall_bad = 0; timeout = 0;
    @(negedge CK);
    start_g = 1'b1; mode_g = m; ready_g = 1'b1;
    while (1) begin
      @(negedge CK);
      cyc++;
      if (!hold) start_g = 1'b0;
      if (pulse_at == cyc) start_g = 1'b1;
      mode_g = 2'($urandom);
      if (g_busy) busy_cnt++;
      if (after >= 0 && g_busy) post_busy++;
      if (g_done) begin
        done_cnt++;
        start_g = 1'b0;
        if (after < 0) after = cyc;
      end
      if (g_valid && first_valid < 0) first_valid = cyc;
      ready_g = 1'b1;
      if (g_valid) begin
        if (q_vec.size() == stall_idx && left > 0) begin
          if (left == stall_n) begin
            sv = g_vec; sd = g_din; sr = g_resp;
          end else if (g_vec !== sv || g_din !== sd || g_resp !== sr) begin
            stall_bad++;
          end
          ready_g = 1'b0;
          left--;
        end else begin
          q_vec.push_back(int'(g_vec));
          q_resp.push_back(int'(g_resp));
        end
      end
      if (after >= 0 && cyc >= after + 4) break;
      if (cyc > 400) begin
        timeout = 1;
        break;
      end
    end
    start_g = 1'b0;
    ready_g = 1'b1;
  endtask

  task automatic test_reset;
    #1 rst_a = 1'b0; rst_b = 1'b0;
    #1;
    checks++;
    if ({din_a, ra.rec_valid, ra.rec_vec, ra.rec_resp, busy_a, done_a} !== 7'd0
        || sig_a !== 16'h0)
      $display("FAIL reset_a: got din=%0h v=%0b vec=%0h r=%0b b=%0b d=%0b sig=%0h want all 0",
               din_a, ra.rec_valid, ra.rec_vec, ra.rec_resp, busy_a, done_a, sig_a);
    else passes++;
    checks++;
    if ({din_b, rb.rec_valid, busy_b, done_b} !== 6'd0 || sig_b !== 16'h0)
      $display("FAIL reset_b: got din=%0h v=%0b b=%0b d=%0b sig=%0h want all 0",
               din_b, rb.rec_valid, busy_b, done_b, sig_b);
    else passes++;
    #8 rst_a = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_ascending;
    sel = 1'b0; tt_a = 4'b1000;
    run_sweep(2'b00, 0, -1, -1, 0);
    checks++;
    if (timeout || rec_errs(0, 2, 0) != 0)
      $display("FAIL asc_records: got errs=%0d to=%0b want 0", rec_errs(0, 2, 0), timeout);
    else passes++;
    checks++;
    if (busy_cnt != 8 || done_cnt != 1 || first_valid != 2)
      $display("FAIL asc_timing: got busy=%0d done=%0d fv=%0d want 8 1 2",
               busy_cnt, done_cnt, first_valid);
    else passes++;
    checks++;
    if (sig_a !== 16'h0001)
      $display("FAIL asc_sig: got %0h want 0001", sig_a);
    else passes++;
    checks++;
    if (din_a !== 2'b11)
      $display("FAIL asc_idle_din: got %0h want 3", din_a);
    else passes++;
  endtask

  task automatic test_gray;
    sel = 1'b0; tt_a = 4'b0110;
    run_sweep(2'b01, 0, -1, -1, 0);
    checks++;
    if (timeout || rec_errs(0, 2, 1) != 0)
      $display("FAIL gray_records: got errs=%0d to=%0b want 0", rec_errs(0, 2, 1), timeout);
    else passes++;
    checks++;
    if (sig_a !== 16'h0005)
      $display("FAIL gray_sig: got %0h want 0005", sig_a);
    else passes++;
  endtask

  task automatic test_descending;
    sel = 1'b0; tt_a = 4'b1000;
    run_sweep(2'b10, 0, -1, -1, 0);
    checks++;
    if (timeout || rec_errs(0, 2, 2) != 0)
      $display("FAIL desc_records: got errs=%0d to=%0b want 0", rec_errs(0, 2, 2), timeout);
    else passes++;
    checks++;
    if (sig_a !== 16'h0008 || din_a !== 2'b00)
      $display("FAIL desc_sig: got sig=%0h din=%0h want 0008 0", sig_a, din_a);
    else passes++;
  endtask

  task automatic test_reserved;
    sel = 1'b0; tt_a = 4'($urandom);
    run_sweep(2'b11, 0, -1, -1, 0);
    checks++;
    if (timeout || rec_errs(0, 2, 3) != 0 || sig_a !== exp_sig(0, 2, 3))
      $display("FAIL reserved: got errs=%0d sig=%0h want 0 %0h",
               rec_errs(0, 2, 3), sig_a, exp_sig(0, 2, 3));
    else passes++;
  endtask

  task automatic test_backpressure;
    sel = 1'b0; tt_a = 4'b1000;
    run_sweep(2'b00, 0, -1, 1, 3);
    checks++;
    if (stall_bad != 0)
      $display("FAIL bp_stable: got %0d changes want 0", stall_bad);
    else passes++;
    checks++;
    if (timeout || rec_errs(0, 2, 0) != 0)
      $display("FAIL bp_records: got errs=%0d want 0", rec_errs(0, 2, 0));
    else passes++;
    checks++;
    if (busy_cnt != 11 || done_cnt != 1 || sig_a !== 16'h0001)
      $display("FAIL bp_timing: got busy=%0d done=%0d sig=%0h want 11 1 0001",
               busy_cnt, done_cnt, sig_a);
    else passes++;
  endtask

  task automatic test_reset_mid;
    int dn;
    bit hit;
    logic [1:0] m;
    sel = 1'b0; tt_a = 4'b1000; hit = 0; dn = 0;
    @(negedge CK);
    start_g = 1'b1; mode_g = 2'b00; ready_g = 1'b1;
    @(negedge CK);
    start_g = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (busy_a && din_a == 2'b10) begin
        hit = 1;
        break;
      end
      @(negedge CK);
    end
    checks++;
    if (!hit) $display("FAIL rst_mid_reach: got no third vector want reached");
    else passes++;
    #2 rst_a = 1'b0;
    #1;
    checks++;
    if ({din_a, ra.rec_valid, ra.rec_vec, ra.rec_resp, busy_a, done_a} !== 7'd0
        || sig_a !== 16'h0)
      $display("FAIL rst_mid_clear: got din=%0h v=%0b b=%0b sig=%0h want all 0",
               din_a, ra.rec_valid, busy_a, sig_a);
    else passes++;
    @(negedge CK);
    rst_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CK);
      if (done_a || busy_a) dn++;
    end
    checks++;
    if (dn != 0) $display("FAIL rst_mid_nodone: got %0d active cycles want 0", dn);
    else passes++;
    tt_a = 4'($urandom);
    m = 2'($urandom);
    run_sweep(m, 0, -1, -1, 0);
    checks++;
    if (timeout || rec_errs(0, 2, m) != 0 || sig_a !== exp_sig(0, 2, m))
      $display("FAIL rst_mid_rerun: got errs=%0d sig=%0h want 0 %0h",
               rec_errs(0, 2, m), sig_a, exp_sig(0, 2, m));
    else passes++;
  endtask

  task automatic test_start_held;
    sel = 1'b0; tt_a = 4'($urandom);
    run_sweep(2'b01, 1, -1, -1, 0);
    checks++;
    if (done_cnt != 1 || busy_cnt != 8 || post_busy != 0 || rec_errs(0, 2, 1) != 0)
      $display("FAIL start_held: got done=%0d busy=%0d post=%0d want 1 8 0",
               done_cnt, busy_cnt, post_busy);
    else passes++;
    run_sweep(2'b10, 0, 3, -1, 0);
    checks++;
    if (done_cnt != 1 || busy_cnt != 8 || post_busy != 0 || rec_errs(0, 2, 2) != 0)
      $display("FAIL start_pulse: got done=%0d busy=%0d post=%0d want 1 8 0",
               done_cnt, busy_cnt, post_busy);
    else passes++;
  endtask

  task automatic test_wide;
    logic [1:0] m;
    sel = 1'b1; tt_b = 8'($urandom);
    run_sweep(2'b00, 0, -1, -1, 0);
    checks++;
    if (timeout || rec_errs(1, 3, 0) != 0)
      $display("FAIL wide_records: got errs=%0d want 0", rec_errs(1, 3, 0));
    else passes++;
    checks++;
    if (busy_cnt != 32 || done_cnt != 1 || first_valid != 4)
      $display("FAIL wide_timing: got busy=%0d done=%0d fv=%0d want 32 1 4",
               busy_cnt, done_cnt, first_valid);
    else passes++;
    checks++;
    if (sig_b !== exp_sig(1, 3, 0))
      $display("FAIL wide_sig: got %0h want %0h", sig_b, exp_sig(1, 3, 0));
    else passes++;
    m = 2'($urandom);
    tt_b = 8'($urandom);
    run_sweep(m, 0, -1, 5, 2);
    checks++;
    if (timeout || rec_errs(1, 3, m) != 0 || sig_b !== exp_sig(1, 3, m)
        || busy_cnt != 34 || stall_bad != 0)
      $display("FAIL wide_rand: got errs=%0d sig=%0h busy=%0d want 0 %0h 34",
               rec_errs(1, 3, m), sig_b, busy_cnt, exp_sig(1, 3, m));
    else passes++;
    sel = 1'b0;
  endtask

  task automatic test_random;
    logic [1:0] m;
    int si, sn;
    sel = 1'b0;
    for (int k = 0; k < 6; k++) begin
      m = 2'($urandom);
      tt_a = 4'($urandom);
      si = int'($urandom_range(0, 3));
      sn = int'($urandom_range(0, 4));
      run_sweep(m, 0, -1, si, sn);
      checks++;
      if (timeout || rec_errs(0, 2, m) != 0 || sig_a !== exp_sig(0, 2, m)
          || busy_cnt != 8 + sn || done_cnt != 1 || stall_bad != 0)
        $display("FAIL random_%0d: got errs=%0d sig=%0h busy=%0d done=%0d want 0 %0h %0d 1",
                 k, rec_errs(0, 2, m), sig_a, busy_cnt, done_cnt,
                 exp_sig(0, 2, m), 8 + sn);
      else passes++;
    end
  endtask

  initial begin
    test_reset;
    test_ascending;
    test_gray;
    test_descending;
    test_reserved;
    test_backpressure;
    test_reset_mid;
    test_start_held;
    test_wide;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
